// File: rtl/minimips_pc_pkg.sv
// Shared defaults and types for the fetch-stage PC generator.
//   XLEN_DEFAULT          default PC / address width
//   RESET_VECTOR_DEFAULT  PC after reset
//   TRAP_VECTOR_DEFAULT   PC after a trap request
//   INC_DEFAULT           bytes per instruction
//   pc_src_e              next-PC source chosen by the priority mux
package minimips_pc_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0080;
    localparam int          INC_DEFAULT          = 4;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_REDIR,
        SRC_HOLD,
        SRC_RAS,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk    clock, rising edge
//   rst    asynchronous reset, active-high (pointer and count only)
//   push   write wdata above the current top
//   pop    drop the top entry (ignored when empty)
//   flush  empty the stack
//   wdata  return address to store
//   top    current top entry (undefined when count is 0)
//   count  number of valid entries, saturates at DEPTH
// push together with an effective pop replaces the top in place.
module pc_ras
    import minimips_pc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_top;
    logic            pop_ok;

    // ptr is the next free slot; DEPTH is a power of two so wrap is free.
    assign ptr_top = ptr - PW'(1);
    assign top     = mem[ptr_top];
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count != FULL)
                count <= count + CW'(1);
        end else if (pop_ok) begin
            ptr   <= ptr_top;
            count <= count - CW'(1);
        end
    end

    // Entry contents are not reset; count qualifies them.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push && pop_ok)
                mem[ptr_top] <= wdata;
            else if (push)
                mem[ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator with return-address prediction.
//   CLK         clock, rising edge
//   RST         asynchronous reset, active-high
//   StallF      hold PCF (hazard unit)
//   RedirectE   execute-stage redirect, target in RedirectPC
//   RedirectPC  redirect target (low log2(INC) bits ignored)
//   TrapReq     exception / interrupt redirect to TRAP_VECTOR
//   CallF       predecode: instruction at PCF is a call
//   RetF        predecode: instruction at PCF is a return
//   PCF         current fetch PC
//   PCPlusF     PCF + INC, combinational, wraps silently
//   PredRetF    PCF came from a RAS pop
//   RasCount    valid RAS entries
// Priority: trap > redirect > stall > RAS return > sequential.
module pc_gen_unit
    import minimips_pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
    parameter int              INC          = INC_DEFAULT,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           StallF,
    input  logic                           RedirectE,
    input  logic [XLEN-1:0]                RedirectPC,
    input  logic                           TrapReq,
    input  logic                           CallF,
    input  logic                           RetF,
    output logic [XLEN-1:0]                PCF,
    output logic [XLEN-1:0]                PCPlusF,
    output logic                           PredRetF,
    output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount
);

    // Clears the sub-instruction offset of a redirect target.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));

    pc_src_e         src;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_flush;

    assign PCPlusF = PCF + XLEN'(INC);

    always_comb begin
        src = SRC_SEQ;
        if (TrapReq)
            src = SRC_TRAP;
        else if (RedirectE)
            src = SRC_REDIR;
        else if (StallF)
            src = SRC_HOLD;
        else if (RetF && (RasCount != '0))
            src = SRC_RAS;
    end

    // Predecode hints only count when the fetch actually advances.
    assign ras_push  = CallF && ((src == SRC_RAS) || (src == SRC_SEQ));
    assign ras_pop   = (src == SRC_RAS);
    assign ras_flush = (src == SRC_TRAP);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (CLK),
        .rst   (RST),
        .push  (ras_push),
        .pop   (ras_pop),
        .flush (ras_flush),
        .wdata (PCPlusF),
        .top   (ras_top),
        .count (RasCount)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PCF      <= RESET_VECTOR;
            PredRetF <= 1'b0;
        end else begin
            case (src)
                SRC_TRAP: begin
                    PCF      <= TRAP_VECTOR;
                    PredRetF <= 1'b0;
                end
                SRC_REDIR: begin
                    PCF      <= RedirectPC & ALIGN_MASK;
                    PredRetF <= 1'b0;
                end
                SRC_HOLD: begin
                    PCF      <= PCF;
                    PredRetF <= PredRetF;
                end
                SRC_RAS: begin
                    PCF      <= ras_top;
                    PredRetF <= 1'b1;
                end
                default: begin
                    PCF      <= PCPlusF;
                    PredRetF <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redir, trap, call, ret;
    logic [31:0] rpc;
    logic [31:0] pcf, pcplus;
    logic        pred;
    logic [2:0]  cnt;

    logic        redir8;
    logic [7:0]  rpc8;
    logic [7:0]  pcf8, pcplus8;
    logic        pred8;
    logic [2:0]  cnt8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pred;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .CLK(clk), .RST(rst), .StallF(stall), .RedirectE(redir), .RedirectPC(rpc),
        .TrapReq(trap), .CallF(call), .RetF(ret), .PCF(pcf), .PCPlusF(pcplus),
        .PredRetF(pred), .RasCount(cnt)
    );

    pc_gen_unit #(.XLEN(8)) dut8 (
        .CLK(clk), .RST(rst), .StallF(1'b0), .RedirectE(redir8), .RedirectPC(rpc8),
        .TrapReq(1'b0), .CallF(1'b0), .RetF(1'b0), .PCF(pcf8), .PCPlusF(pcplus8),
        .PredRetF(pred8), .RasCount(cnt8)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, then compare
    // the registered outputs just after the edge.
    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] tgt,
                        input logic t, input logic c, input logic rt,
                        input logic [31:0] epc, input logic epred, input logic [2:0] ecnt);
        exp_t e;
        exp_t got;
        stall = s; redir = r; rpc = tgt; trap = t; call = c; ret = rt;
        e.tag = tag; e.pc = epc; e.pred = epred; e.cnt = ecnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall = 0; redir = 0; rpc = '0; trap = 0; call = 0; ret = 0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk32({got.tag, ".pc"}, pcf, got.pc);
            chk32({got.tag, ".pcplus"}, pcplus, got.pc + 32'd4);
            chk32({got.tag, ".pred"}, {31'd0, pred}, {31'd0, got.pred});
            chk32({got.tag, ".cnt"}, {29'd0, cnt}, {29'd0, got.cnt});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; stall = 0; redir = 0; rpc = '0; trap = 0; call = 0; ret = 0;
        redir8 = 0; rpc8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk32("rst.pc", pcf, 32'h0);
        chk32("rst.pred", {31'd0, pred}, 32'd0);
        chk32("rst.cnt", {29'd0, cnt}, 32'd0);
        rst = 0;

        step("seq0", 0, 0, 0, 0, 0, 0, 32'h4, 0, 0);
        step("seq1", 0, 0, 0, 0, 1, 0, 32'h8, 0, 1);

        // Asynchronous reset mid-cycle
        #3 rst = 1;
        #1;
        chk32("arst.pc", pcf, 32'h0);
        chk32("arst.cnt", {29'd0, cnt}, 32'd0);
        @(posedge clk);
        #1;
        chk32("arst.hold", pcf, 32'h0);
        rst = 0;
        step("seq_a", 0, 0, 0, 0, 0, 0, 32'h4, 0, 0);
        step("seq_b", 0, 0, 0, 0, 0, 0, 32'h8, 0, 0);
        step("seq_c", 0, 0, 0, 0, 0, 0, 32'hC, 0, 0);

        // Stall versus redirect
        step("redir8", 0, 1, 32'h8, 0, 0, 0, 32'h8, 0, 0);
        step("stall0", 1, 0, 0, 0, 1, 0, 32'h8, 0, 0);
        step("stall1", 1, 0, 0, 0, 0, 0, 32'h8, 0, 0);
        step("stall_redir", 1, 1, 32'h123, 0, 0, 0, 32'h120, 0, 0);

        // Trap priority and flush
        step("tcall0", 0, 0, 0, 0, 1, 0, 32'h124, 0, 1);
        step("tcall1", 0, 0, 0, 0, 1, 0, 32'h128, 0, 2);
        step("trap", 1, 1, 32'h300, 1, 1, 1, 32'h80, 0, 0);
        step("trap_ret", 0, 0, 0, 0, 0, 1, 32'h84, 0, 0);

        // Call / return prediction
        step("cr_r10", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0, 0);
        step("cr_c10", 0, 0, 0, 0, 1, 0, 32'h14, 0, 1);
        step("cr_r40", 0, 1, 32'h40, 0, 1, 0, 32'h40, 0, 1);
        step("cr_c40", 0, 0, 0, 0, 1, 0, 32'h44, 0, 2);
        step("cr_ret0", 0, 0, 0, 0, 0, 1, 32'h44, 1, 1);
        step("cr_hold", 1, 0, 0, 0, 0, 1, 32'h44, 1, 1);
        step("cr_ret1", 0, 0, 0, 0, 0, 1, 32'h14, 1, 0);

        // Overflow: five calls into four entries
        for (int i = 0; i < 5; i++) begin
            step("ov_redir", 0, 1, 32'h10 * i, 0, 0, 0, 32'h10 * i, 0, 3'(i < 4 ? i : 4));
            step("ov_call", 0, 0, 0, 0, 1, 0, 32'h10 * i + 32'h4, 0, 3'(i < 3 ? i + 1 : 4));
        end
        step("ov_ret0", 0, 0, 0, 0, 0, 1, 32'h44, 1, 3);
        step("ov_ret1", 0, 0, 0, 0, 0, 1, 32'h34, 1, 2);
        step("ov_ret2", 0, 0, 0, 0, 0, 1, 32'h24, 1, 1);
        step("ov_ret3", 0, 0, 0, 0, 0, 1, 32'h14, 1, 0);
        step("ov_ret4", 0, 0, 0, 0, 0, 1, 32'h18, 0, 0);

        // Simultaneous call and return replaces top
        step("sim_r10", 0, 1, 32'h10, 0, 0, 0, 32'h10, 0, 0);
        step("sim_c10", 0, 0, 0, 0, 1, 0, 32'h14, 0, 1);
        step("sim_r200", 0, 1, 32'h200, 0, 0, 0, 32'h200, 0, 1);
        step("sim_cr", 0, 0, 0, 0, 1, 1, 32'h14, 1, 1);
        step("sim_ret", 0, 0, 0, 0, 0, 1, 32'h204, 1, 0);
        step("sim_cr_empty", 0, 0, 0, 0, 1, 1, 32'h208, 0, 1);

        // XLEN=8 wrap
        redir8 = 1; rpc8 = 8'hFD;
        @(posedge clk);
        #1;
        redir8 = 0; rpc8 = '0;
        chk32("w8.pc", {24'd0, pcf8}, 32'hFC);
        chk32("w8.plus", {24'd0, pcplus8}, 32'h00);
        @(posedge clk);
        #1;
        chk32("w8.wrap", {24'd0, pcf8}, 32'h00);
        chk32("w8.pred", {31'd0, pred8}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
